// File: rtl/program_loader_pkg.sv
// Shared widths and state encoding for the disk-to-instruction-memory program loader.
package program_loader_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StCopy,
        StDone
    } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Pipelined block copy from disk memory into instruction memory, one word per clock after priming.
// Optional running XOR of copied words on the checksum port when LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int unsigned ADDR_W = program_loader_pkg::ADDR_W,
    parameter int unsigned DATA_W = program_loader_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] srcBase,
    input  logic [ADDR_W-1:0] dstBase,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] diskAddr,
    input  logic [DATA_W-1:0] diskData,
    output logic [DATA_W-1:0] miData,
    output logic [ADDR_W-1:0] miWriteAddr,
    output logic              miWe,
    output logic              busy,
`ifdef LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              done
);
    import program_loader_pkg::*;

    loader_state_e     state;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] len_q;
    // One bit wider than the address so length=4095 never overflows.
    logic [ADDR_W:0]   read_cnt;
    logic [ADDR_W:0]   write_cnt;
    logic [ADDR_W:0]   len_ext;

    assign len_ext = {1'b0, len_q};
    assign miData  = diskData;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StIdle;
            dst_q       <= '0;
            len_q       <= '0;
            read_cnt    <= '0;
            write_cnt   <= '0;
            diskAddr    <= '0;
            miWriteAddr <= '0;
            miWe        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        dst_q     <= dstBase;
                        len_q     <= length;
                        read_cnt  <= '0;
                        write_cnt <= '0;
                        busy      <= 1'b1;
                        if (length == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state    <= StPrime;
                            diskAddr <= srcBase;
                        end
                    end
                end
                StPrime: begin
                    diskAddr    <= diskAddr + ADDR_W'(1);
                    read_cnt    <= (ADDR_W + 1)'(1);
                    miWe        <= 1'b1;
                    miWriteAddr <= dst_q;
                    state       <= StCopy;
                end
                StCopy: begin
                    miWriteAddr <= miWriteAddr + ADDR_W'(1);
                    write_cnt   <= write_cnt + (ADDR_W + 1)'(1);
                    // Reads run one word ahead of writes; stop issuing once all are requested.
                    if (read_cnt < len_ext) begin
                        diskAddr <= diskAddr + ADDR_W'(1);
                        read_cnt <= read_cnt + (ADDR_W + 1)'(1);
                    end
                    if (write_cnt == len_ext - (ADDR_W + 1)'(1)) begin
                        miWe  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            checksum <= '0;
        end else if (state == StIdle && start) begin
            checksum <= '0;
        end else if (miWe) begin
            checksum <= checksum ^ miData;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes/done events are queued at start, a monitor
// pops and compares them whenever miWe or done is seen.
module tb_program_loader;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] srcBase, dstBase, length;
    logic [AW-1:0] diskAddr, miWriteAddr;
    logic [DW-1:0] diskData, miData;
    logic          miWe, busy, done;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    program_loader dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .srcBase     (srcBase),
        .dstBase     (dstBase),
        .length      (length),
        .diskAddr    (diskAddr),
        .diskData    (diskData),
        .miData      (miData),
        .miWriteAddr (miWriteAddr),
        .miWe        (miWe),
        .busy        (busy),
`ifdef LOADER_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .done        (done)
    );

    always #5 clock = ~clock;

    // Disk memory with one-cycle read latency.
    logic [DW-1:0] disk [0:4095];
    always @(posedge clock) diskData <= disk[diskAddr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            cycle;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    typedef struct {
        int            cycle;
        logic [DW-1:0] sum;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int  busy_lo = 1;
    int  busy_hi = 0;
    bit  mon_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        wr_t w;
        dn_t d;
        if (mon_en) begin
            check("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
            if (miWe) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 64'(miWriteAddr), 64'hFFFF_FFFF);
                end else begin
                    w = wq.pop_front();
                    check("write_cycle", 64'(cyc), 64'(w.cycle));
                    check("write_addr", 64'(miWriteAddr), 64'(w.addr));
                    check("write_data", 64'(miData), 64'(w.data));
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    d = dq.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d.cycle));
`ifdef LOADER_CHECKSUM_EN
                    check("checksum", 64'(checksum), 64'(d.sum));
`endif
                end
            end
        end
    end

    // Issue one copy; abort_k >= 0 resets the block after abort_k writes, inject pulses a
    // spurious start mid-copy.
    task automatic do_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len,
                           input int abort_k, input bit inject);
        int            c0;
        int            dcyc;
        int            nw;
        logic [DW-1:0] sum;
        wr_t           w;
        dn_t           d;
        @(negedge clock);
        c0      = cyc;
        start   = 1'b1;
        srcBase = src;
        dstBase = dst;
        length  = len[AW-1:0];
        nw      = (abort_k >= 0) ? abort_k : len;
        sum     = '0;
        for (int k = 0; k < nw; k++) begin
            w.cycle = c0 + 2 + k;
            w.addr  = AW'((int'(dst) + k) % 4096);
            w.data  = disk[(int'(src) + k) % 4096];
            sum     = sum ^ w.data;
            wq.push_back(w);
        end
        dcyc = (len == 0) ? c0 + 1 : c0 + len + 2;
        busy_lo = c0 + 1;
        if (abort_k < 0) begin
            d.cycle = dcyc;
            d.sum   = sum;
            dq.push_back(d);
            busy_hi = dcyc;
        end else begin
            busy_hi = c0 + 1 + abort_k;
        end
        @(negedge clock);
        start   = 1'b0;
        srcBase = AW'($urandom);
        dstBase = AW'($urandom);
        length  = AW'($urandom);
        if (abort_k >= 0) begin
            while (cyc < c0 + 1 + abort_k) @(negedge clock);
            reset   = 1'b1;
            start   = 1'b1;
            length  = 12'd5;
            @(negedge clock);
            reset = 1'b0;
            start = 1'b0;
            repeat (3) @(negedge clock);
        end else begin
            while (cyc < dcyc) begin
                @(negedge clock);
                if (inject && cyc == c0 + 3) begin
                    start   = 1'b1;
                    srcBase = AW'($urandom);
                    dstBase = AW'($urandom);
                    length  = AW'($urandom_range(1, 20));
                end else begin
                    start = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) disk[i] = $urandom;
        disk[12'h100] = 32'hAAAA_0001;
        disk[12'h101] = 32'hBBBB_0002;
        disk[12'h102] = 32'hCCCC_0003;
        disk[12'h103] = 32'hDDDD_0004;
        reset   = 1'b1;
        start   = 1'b1;
        srcBase = 12'h123;
        dstBase = 12'h456;
        length  = 12'd7;
        repeat (3) @(negedge clock);
        check("rst_diskAddr", 64'(diskAddr), 64'h0);
        check("rst_miWriteAddr", 64'(miWriteAddr), 64'h0);
        check("rst_miWe", 64'(miWe), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
`ifdef LOADER_CHECKSUM_EN
        check("rst_checksum", 64'(checksum), 64'h0);
`endif
        reset  = 1'b0;
        start  = 1'b0;
        mon_en = 1'b1;

        do_copy(12'h100, 12'h000, 4, -1, 1'b0);
        do_copy(AW'($urandom), AW'($urandom), 0, -1, 1'b0);
        do_copy(12'h200, 12'hFFE, 4, -1, 1'b0);
        do_copy(12'hFFF, 12'h010, 4, -1, 1'b0);
        do_copy(12'h300, 12'h400, 10, -1, 1'b1);
        do_copy(12'h500, 12'h600, 8, 3, 1'b0);
        do_copy(12'h700, 12'h800, 5, -1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            do_copy(AW'($urandom), AW'($urandom), int'($urandom_range(0, 40)), -1, 1'b0);
        end
        do_copy(AW'($urandom), AW'($urandom), 4095, -1, 1'b0);

        repeat (5) @(negedge clock);
        check("writes_left", 64'(wq.size()), 64'h0);
        check("dones_left", 64'(dq.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Copies a contiguous block of 32-bit instruction words from the secondary (disk) memory into instruction memory. It sits directly upstream of the instruction memory and drives that memory's write port: write data, write address and write enable. The BIOS/SO start it to load the OS or a process image at a chosen instruction-memory base address. The copy is pipelined, so the block sustains one word per clock after a single priming cycle.

## Interface
Parameters:
- ADDR_W, 12, address width for both disk and instruction memory
- DATA_W, 32, instruction word width

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- start  in  1  request a copy; sampled only in IDLE
- srcBase  in  ADDR_W  first disk word address
- dstBase  in  ADDR_W  first instruction-memory word address
- length  in  ADDR_W  number of words to copy (0..4095)
- diskAddr  out  ADDR_W  read address to disk memory (registered)
- diskData  in  DATA_W  disk read data; valid the cycle after diskAddr is presented
- miData  out  DATA_W  instruction-memory write data (combinational from diskData)
- miWriteAddr  out  ADDR_W  instruction-memory write address (registered)
- miWe  out  1  instruction-memory write enable (registered)
- busy  out  1  high while a copy is in progress, including the DONE cycle
- done  out  1  one-cycle pulse when a copy completes
- checksum  out  DATA_W  running XOR of copied words; present only with LOADER_CHECKSUM_EN

## Operation
- States: IDLE, PRIME, COPY, DONE.
- IDLE:
  - start=1 captures srcBase, dstBase and length.
  - length=0 → DONE directly, with no writes.
  - Otherwise → PRIME, with diskAddr←srcBase.
- PRIME:
  - diskAddr is presented to disk memory.
  - readCnt←1 and diskAddr←srcBase+1.
  - → COPY, with miWe←1 and miWriteAddr←dstBase.
- COPY, per cycle:
  - The word on diskData is written to miWriteAddr, because miWe is high.
  - miWriteAddr and writeCnt increment.
  - diskAddr and readCnt increment while readCnt<length.
  - On the cycle of the last write (writeCnt=length−1): miWe←0 at the next edge, → DONE.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - → IDLE.
- start is ignored while not in IDLE. Captured operands do not change during a copy.
- Address arithmetic is modulo 2^ADDR_W on both sides: a copy past 4095 wraps to 0.
- Counters are ADDR_W+1 bits wide, so length=4095 completes without overflow.
- Reset values: diskAddr=0, miWriteAddr=0, miWe=0, busy=0, done=0, checksum=0, state=IDLE.
- Reset mid-copy: the state returns to IDLE at that edge and miWe=0 from that edge on. The partial copy is abandoned and done does not pulse.
- If start and reset are asserted together, reset wins.

## Timing
- The cycle in which start is sampled is cycle 0.
- PRIME is cycle 1. Writes occur at the ends of cycles 2..length+1, one word per cycle with no bubbles. DONE is cycle length+2.
- length=0: DONE in cycle 1.
- busy rises at the edge ending cycle 0 and falls at the edge ending the DONE cycle. start may be re-asserted in the next cycle (IDLE).
- Disk read latency is fixed at 1 cycle. The disk memory is not stalled and the block provides no backpressure.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The checksum port exists.
  - It is cleared when start is accepted and XORs miData on every cycle with miWe=1.
  - It holds its value after DONE until the next start or reset.
- LOADER_CHECKSUM_EN undefined: the port and its logic are omitted. All other behaviour is identical.

## Structure
- Shared package: ADDR_W and DATA_W constants, and the loader state enum (IDLE, PRIME, COPY, DONE).
- There are no sub-modules. The checksum is a few lines inside the macro guard.

## Test plan
- srcBase=0x100, dstBase=0x000, length=4, disk[0x100..0x103]=A,B,C,D → mi writes A..D at addresses 0..3 in cycles 2..5; done in cycle 6; checksum=A^B^C^D.
- length=0, start → no miWe; done pulses in cycle 1; busy high for one cycle only.
- dstBase=0xFFE, length=4 → writes go to addresses 0xFFE, 0xFFF, 0x000, 0x001; srcBase=0xFFF wraps reads the same way.
- start pulsed during COPY with different operands → ignored; the original copy completes unchanged.
- reset asserted in the 3rd COPY cycle of length=8 → miWe=0 from the next cycle; no done; busy=0; a new start then runs normally.
- length=4095 → exactly 4095 writes, continuous miWe; done at cycle 4097.
